apb_pad_reader: RTL and testbench

- APB3 slave peripheral in the fabric, directly downstream of the MSS APB master port; it sits behind the fabric APB3 interconnect in one slot.
- Periodically polls a serial game controller (latch/clock/data, SNES-style) and keeps the live button word.
- Pushes each changed button word into a small FIFO that firmware drains over APB.
- Drives a level interrupt towards the MSS fabric interrupt.

---
 rtl/apb_pad_reader.sv | 196 +++++++++++++++++++
 tb/tb_apb_pad_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_pad_reader.sv
// apb_pad_reader: APB3 slave that polls an SNES-style serial pad and queues changed button words
// Ports: PCLK/PRESET fabric clock and async active-high reset; PSEL/PENABLE/PWRITE/PADDR/PWDATA/
//   PRDATA/PREADY/PSLVERR APB3 slave (PADDR[3:2]: 0 CTRL, 1 STATUS, 2 DATA pop, 3 CUR);
//   PAD_LATCH/PAD_CLK/PAD_DATA controller link; IRQ level interrupt.
// Optional: define PAD_TIMESTAMP_EN to tag FIFO entries and CUR with a 16-bit poll sequence in [31:16].
module apb_pad_reader #(
    parameter int NBITS      = 12,
    parameter int HALF_DIV   = 600,
    parameter int POLL_DIV   = 1666667,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PAD_LATCH,
    output logic        PAD_CLK,
    input  logic        PAD_DATA,
    output logic        IRQ
);
    localparam int TW = $clog2(2 * HALF_DIV + 1);
    localparam int PW = $clog2(POLL_DIV + 1);
    localparam int BW = $clog2(NBITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PAD_TIMESTAMP_EN
    localparam int FW = NBITS + 16;
`else
    localparam int FW = NBITS;
`endif
    localparam logic [TW-1:0] T_LATCH = TW'(2 * HALF_DIV - 1);
    localparam logic [TW-1:0] T_HALF  = TW'(HALF_DIV - 1);
    localparam logic [PW-1:0] P_WRAP  = PW'(POLL_DIV - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(NBITS);
    localparam logic [4:0]    C_FULL  = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, CLK_LO, CLK_HI, DONE} state_t;

    state_t           r_state;
    logic [TW-1:0]    r_tmr;
    logic [PW-1:0]    r_poll;
    logic [BW-1:0]    r_bits;
    logic [NBITS-1:0] r_shift, r_cur;
    logic [1:0]       r_sync;
    logic             r_en, r_ie, r_ovf;
    logic [FW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [4:0]       r_cnt;
`ifdef PAD_TIMESTAMP_EN
    logic [15:0]      r_seq;
`endif

    logic          w_acc, w_wr, w_rd, w_empty, w_full, w_pop, w_push, w_in, w_wrap, w_unused;
    logic [1:0]    w_addr;
    logic [FW-1:0] w_head, w_entry;
    logic [31:0]   w_data, w_cur, w_status;

    assign w_addr   = PADDR[3:2];
    assign w_acc    = PSEL & PENABLE;
    assign w_wr     = w_acc & PWRITE;
    assign w_rd     = w_acc & ~PWRITE;
    assign w_empty  = r_cnt == 5'd0;
    assign w_full   = r_cnt == C_FULL;
    assign w_pop    = w_rd & (w_addr == 2'd2) & ~w_empty;
    assign w_push   = (r_state == DONE) & r_en & (r_shift != r_cur);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push then.
    assign w_in     = w_push & (~w_full | w_pop);
    assign w_wrap   = r_poll == P_WRAP;
    assign w_head   = r_mem[r_rp];
    assign w_status = {24'd0, r_cnt[3:0], 1'b0, r_ovf, w_full, ~w_empty};
    assign w_unused = &{1'b0, PADDR[7:4], PADDR[1:0], PWDATA[31:3]};
`ifdef PAD_TIMESTAMP_EN
    assign w_entry  = {r_seq, r_shift};
    assign w_data   = w_empty ? 32'd0 : {w_head[FW-1:NBITS], 16'(w_head[NBITS-1:0])};
    assign w_cur    = {r_seq, 16'(r_cur)};
`else
    assign w_entry  = r_shift;
    assign w_data   = w_empty ? 32'd0 : 32'(w_head);
    assign w_cur    = 32'(r_cur);
`endif

    assign PREADY  = 1'b1;
    assign PSLVERR = w_acc & (PWRITE ? w_addr[1] : (w_addr == 2'd2) & w_empty);

    always_comb begin
        PRDATA = !PSEL ? 32'd0 :
                 w_addr == 2'd0 ? {30'd0, r_ie, r_en} :
                 w_addr == 2'd1 ? w_status :
                 w_addr == 2'd2 ? w_data : w_cur;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_en   <= 1'b0;
            r_ie   <= 1'b0;
            r_ovf  <= 1'b0;
            IRQ    <= 1'b0;
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], PAD_DATA};
            IRQ    <= r_ie & (~w_empty | r_ovf);
            if (w_wr && w_addr == 2'd0)
                {r_ie, r_en} <= PWDATA[1:0];
            // A drop in the same cycle as a W1C keeps the flag set so no overflow goes unseen.
            if (w_push && !w_in)
                r_ovf <= 1'b1;
            else if (w_wr && w_addr == 2'd1 && PWDATA[2])
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= 5'd0;
        end else begin
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            if (w_in)
                r_wp <= r_wp + AW'(1);
            r_cnt <= r_cnt + 5'(w_in) - 5'(w_pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_in)
            r_mem[r_wp] <= w_entry;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= IDLE;
            r_tmr     <= '0;
            r_poll    <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_cur     <= '0;
            PAD_LATCH <= 1'b0;
            PAD_CLK   <= 1'b1;
`ifdef PAD_TIMESTAMP_EN
            r_seq     <= 16'd0;
`endif
        end else begin
            r_poll <= (!r_en || w_wrap) ? '0 : r_poll + PW'(1);
            if (!r_en) begin
                r_state   <= IDLE;
                PAD_LATCH <= 1'b0;
                PAD_CLK   <= 1'b1;
            end else begin
                r_tmr <= r_tmr + TW'(1);
                case (r_state)
                    IDLE: if (w_wrap) begin
                        r_state   <= LATCH;
                        PAD_LATCH <= 1'b1;
                        r_tmr     <= '0;
                        r_bits    <= '0;
                    end
                    LATCH: if (r_tmr == T_LATCH) begin
                        r_state   <= SAMPLE;
                        PAD_LATCH <= 1'b0;
                    end
                    SAMPLE: begin
                        // First bit shifted in ends up in bit 0 after NBITS samples.
                        r_shift <= (r_shift >> 1) | (NBITS'(~r_sync[1]) << (NBITS - 1));
                        r_bits  <= r_bits + BW'(1);
                        r_state <= CLK_LO;
                        PAD_CLK <= 1'b0;
                        r_tmr   <= '0;
                    end
                    CLK_LO: if (r_tmr == T_HALF) begin
                        r_state <= CLK_HI;
                        PAD_CLK <= 1'b1;
                        r_tmr   <= '0;
                    end
                    CLK_HI: if (r_tmr == T_HALF)
                        r_state <= r_bits == B_LAST ? DONE : SAMPLE;
                    DONE: begin
                        if (r_shift != r_cur)
                            r_cur <= r_shift;
`ifdef PAD_TIMESTAMP_EN
                        r_seq <= r_seq + 16'd1;
`endif
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_apb_pad_reader.sv
// tb_apb_pad_reader: directed bench for apb_pad_reader with a behavioural SNES pad model
module tb_apb_pad_reader;
    logic        PCLK = 1'b0, PRESET = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'd0;
    logic [31:0] PWDATA = 32'd0, PRDATA;
    logic        PREADY, PSLVERR, PAD_LATCH, PAD_CLK, PAD_DATA, IRQ;

    apb_pad_reader #(.NBITS(12), .HALF_DIV(2), .POLL_DIV(200), .FIFO_DEPTH(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .PAD_LATCH(PAD_LATCH), .PAD_CLK(PAD_CLK), .PAD_DATA(PAD_DATA), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    // Pad model: latch reloads bit 0, each PAD_CLK rising edge advances; pressed buttons pull data low.
    logic [15:0] btn = 16'd0;
    int pidx = 0;
    always @(posedge PAD_CLK or posedge PAD_LATCH) pidx = PAD_LATCH ? 0 : pidx + 1;
    assign PAD_DATA = ~btn[pidx[3:0]];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        rd = PRDATA;
        err = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        apb(1'b0, addr, 32'd0, d, e);
        chk(nm, d, exp);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic e;
        apb(1'b1, addr, wd, d, e);
    endtask

    task automatic wait_latch(input string nm);
        logic prev, seen;
        prev = PAD_LATCH;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge PCLK);
            seen = PAD_LATCH & ~prev;
            prev = PAD_LATCH;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic run_poll(output int lc, output int pulses);
        logic pc;
        wait_latch("poll start");
        lc = 1;
        pulses = 0;
        pc = PAD_CLK;
        repeat (70) begin
            @(negedge PCLK);
            if (PAD_LATCH) lc++;
            if (pc && !PAD_CLK) pulses++;
            pc = PAD_CLK;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_err;
    } vec_t;
    vec_t vt[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc, pulses;
        logic [31:0] d;
        logic e;
        logic [11:0] w[10];

        vt[0] = '{1'b0, 8'h00, 32'd0,     32'd0, 1'b0};
        vt[1] = '{1'b0, 8'h04, 32'd0,     32'd0, 1'b0};
        vt[2] = '{1'b0, 8'h0C, 32'd0,     32'd0, 1'b0};
        vt[3] = '{1'b0, 8'h08, 32'd0,     32'd0, 1'b1};
        vt[4] = '{1'b1, 8'h08, 32'hFFF,   32'd0, 1'b1};
        vt[5] = '{1'b1, 8'h0C, 32'hFFF,   32'd0, 1'b1};
        vt[6] = '{1'b1, 8'h04, 32'h4,     32'd0, 1'b0};
        vt[7] = '{1'b0, 8'h04, 32'd0,     32'd0, 1'b0};
        vt[8] = '{1'b0, 8'h0C, 32'd0,     32'd0, 1'b0};
        for (int i = 0; i < 10; i++) w[i] = 12'h100 + 12'(i * 'h11);

        repeat (3) @(negedge PCLK);
        chk("reset PAD_CLK", 32'(PAD_CLK), 32'd1);
        chk("reset PAD_LATCH", 32'(PAD_LATCH), 32'd0);
        chk("reset IRQ", 32'(IRQ), 32'd0);
        chk("reset PRDATA", PRDATA, 32'd0);
        chk("reset PSLVERR", 32'(PSLVERR), 32'd0);
        chk("PREADY", 32'(PREADY), 32'd1);
        PRESET = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apb(vt[i].wr, vt[i].addr, vt[i].wd, d, e);
            if (!vt[i].wr) chk($sformatf("vec%0d data", i), d, vt[i].exp_d);
            chk($sformatf("vec%0d err", i), 32'(e), 32'(vt[i].exp_err));
        end

        btn = 16'h0A5;
        wr(8'h00, 32'h3);
        run_poll(lc, pulses);
        chk("latch cycles", 32'(lc), 32'd4);
        chk("clk pulses", 32'(pulses), 32'd12);
        rd_chk("CUR first", 8'h0C, 32'h0A5);
        rd_chk("STATUS first", 8'h04, 32'h11);
        chk("IRQ first", 32'(IRQ), 32'd1);
        apb(1'b0, 8'h08, 32'd0, d, e);
        chk("DATA first", d, 32'h0A5);
        chk("DATA first err", 32'(e), 32'd0);
        rd_chk("STATUS drained", 8'h04, 32'h00);
        chk("IRQ drained", 32'(IRQ), 32'd0);

        btn = 16'h123;
        repeat (5) run_poll(lc, pulses);
        rd_chk("STATUS same x5", 8'h04, 32'h11);
        rd_chk("DATA same x5", 8'h08, 32'h123);

        for (int i = 0; i < 10; i++) begin
            btn = 16'(w[i]);
            run_poll(lc, pulses);
        end
        rd_chk("STATUS overflow", 8'h04, 32'h87);
        chk("IRQ overflow", 32'(IRQ), 32'd1);
        wr(8'h04, 32'h4);
        rd_chk("STATUS ovf cleared", 8'h04, 32'h83);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("pop%0d", i), 8'h08, 32'(w[i]));
        rd_chk("STATUS after pops", 8'h04, 32'h00);
        rd_chk("CUR last", 8'h0C, 32'(w[9]));

        btn = 16'h3C1; run_poll(lc, pulses);
        btn = 16'h3C2; run_poll(lc, pulses);
        btn = 16'h3C3; run_poll(lc, pulses);
        rd_chk("STATUS count3", 8'h04, 32'h31);
        btn = 16'h3C4;
        wait_latch("timed poll start");
        // Access edge of the read lands 65 edges after latch entry, the DONE push edge.
        repeat (62) @(negedge PCLK);
        apb(1'b0, 8'h08, 32'd0, d, e);
        chk("pop on push", d, 32'h3C1);
        rd_chk("STATUS still 3", 8'h04, 32'h31);
        rd_chk("order b", 8'h08, 32'h3C2);
        rd_chk("order c", 8'h08, 32'h3C3);
        rd_chk("order d", 8'h08, 32'h3C4);

        btn = 16'h055;
        wait_latch("abort poll start");
        // Write access edge enters CLK_LO of bit 3; abort follows on the next edge.
        repeat (17) @(negedge PCLK);
        wr(8'h00, 32'h2);
        chk("clk low pre-abort", 32'(PAD_CLK), 32'd0);
        @(negedge PCLK);
        chk("abort PAD_CLK", 32'(PAD_CLK), 32'd1);
        chk("abort PAD_LATCH", 32'(PAD_LATCH), 32'd0);
        repeat (100) @(negedge PCLK);
        rd_chk("abort no push", 8'h04, 32'h00);
        rd_chk("abort CUR", 8'h0C, 32'h3C4);

        btn = 16'h2AA;
        wr(8'h00, 32'h3);
        run_poll(lc, pulses);
        chk("IRQ pre-reset", 32'(IRQ), 32'd1);
        btn = 16'h155;
        wait_latch("reset poll start");
        repeat (20) @(negedge PCLK);
        chk("clk low pre-reset", 32'(PAD_CLK), 32'd0);
        PRESET = 1'b1;
        #1;
        chk("mid reset PAD_CLK", 32'(PAD_CLK), 32'd1);
        chk("mid reset PAD_LATCH", 32'(PAD_LATCH), 32'd0);
        chk("mid reset IRQ", 32'(IRQ), 32'd0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        rd_chk("post reset CTRL", 8'h00, 32'h0);
        rd_chk("post reset STATUS", 8'h04, 32'h0);
        rd_chk("post reset CUR", 8'h0C, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
